// File: rtl/ftoi_pipe.sv
// ftoi_pipe: two-stage pipelined IEEE-754 binary32 to signed 32-bit integer
// converter. Rounding is to nearest, ties away from zero. One conversion per
// cycle, fixed latency of two cycles, no backpressure.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rstn   in   1   asynchronous active-low reset
//   x      in   32  binary32 operand, sampled when ready=1
//   ready  in   1   request strobe
//   y      out  32  signed integer result, meaningful when valid=1
//   valid  out  1   result strobe, one cycle per accepted request
//
// Build option:
//   FTOI_SATURATE_EN  when defined, out-of-range positive values and NaNs give
//                     0x7FFFFFFF and out-of-range negative values 0x80000000.
//                     When undefined, every out-of-range value, Inf or NaN
//                     gives the integer indefinite 0x80000000.
module ftoi_pipe (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    input  logic        ready,
    output logic [31:0] y,
    output logic        valid
);

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_OVF  = 2'd2
    } range_cls_t;

    // ------------------------------------------------------------------
    // Stage 1: unpack, classify, align the significand
    // ------------------------------------------------------------------
    logic [7:0]  exp_in;
    logic [22:0] frac_in;
    logic [23:0] mant_in;
    logic [7:0]  rshift_full;
    logic [4:0]  rshift;
    logic [7:0]  lshift_full;
    logic [2:0]  lshift;
    logic [31:0] round_tmp;

    range_cls_t  cls_next;
    logic [31:0] mag_next;
    logic        rnd_next;
    logic        s_next;

    range_cls_t  cls_reg;
    logic [31:0] mag_reg;
    logic        rnd_reg;
    logic        s_reg;
    logic        v1_reg;

    assign exp_in      = x[30:23];
    assign frac_in     = x[22:0];
    assign mant_in     = {1'b1, frac_in};
    assign rshift_full = 8'd150 - exp_in;
    assign rshift      = rshift_full[4:0];
    assign lshift_full = exp_in - 8'd150;
    assign lshift      = lshift_full[2:0];

    always_comb begin
        cls_next  = CLS_ZERO;
        mag_next  = 32'd0;
        rnd_next  = 1'b0;
        s_next    = x[31];
        round_tmp = 32'd0;
        if (exp_in <= 8'd125) begin
            // zero, denormal, or |x| < 0.5: rounds to zero, sign dropped
            cls_next = CLS_ZERO;
        end else if (exp_in <= 8'd149) begin
            // fractional part present: the round bit is the most significant
            // bit shifted out, i.e. bit (shift-1) of the significand
            cls_next  = CLS_NORM;
            mag_next  = {8'd0, mant_in} >> rshift;
            round_tmp = {8'd0, mant_in} >> (rshift - 5'd1);
            rnd_next  = round_tmp[0];
        end else if (exp_in <= 8'd157) begin
            cls_next = CLS_NORM;
            mag_next = {8'd0, mant_in} << lshift;
        end else if (exp_in == 8'd158 && x[31] && frac_in == 23'd0) begin
            // exactly -2^31: the only representable value at this exponent;
            // negating 0x80000000 in stage 2 leaves it unchanged
            cls_next = CLS_NORM;
            mag_next = 32'h8000_0000;
        end else begin
            cls_next = CLS_OVF;
`ifdef FTOI_SATURATE_EN
            // NaNs saturate positive regardless of their sign bit
            if (exp_in == 8'd255 && frac_in != 23'd0) begin
                s_next = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cls_reg <= CLS_ZERO;
            mag_reg <= 32'd0;
            rnd_reg <= 1'b0;
            s_reg   <= 1'b0;
            v1_reg  <= 1'b0;
        end else begin
            v1_reg <= ready;
            if (ready) begin
                cls_reg <= cls_next;
                mag_reg <= mag_next;
                rnd_reg <= rnd_next;
                s_reg   <= s_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round, apply sign, substitute out-of-range value
    // ------------------------------------------------------------------
    logic [31:0] rounded;
    logic [31:0] signed_mag;
    logic [31:0] ovf_val;
    logic [31:0] y_next;
    logic [31:0] y_reg;
    logic        valid_reg;

    // Magnitude before rounding is below 2^24 whenever the round bit can be
    // set, so this add never carries out of 32 bits.
    assign rounded    = mag_reg + {31'd0, rnd_reg};
    assign signed_mag = s_reg ? (~rounded + 32'd1) : rounded;

`ifdef FTOI_SATURATE_EN
    assign ovf_val = s_reg ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    assign ovf_val = 32'h8000_0000;
`endif

    always_comb begin
        y_next = 32'd0;
        case (cls_reg)
            CLS_NORM: y_next = signed_mag;
            CLS_OVF:  y_next = ovf_val;
            default:  y_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_reg     <= 32'd0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= v1_reg;
            if (v1_reg) begin
                y_reg <= y_next;
            end
        end
    end

    assign y     = y_reg;
    assign valid = valid_reg;

endmodule
